dec_trigger_seq: RTL and testbench

Parametrised decode-stage PC execute-trigger unit for NUM_TRIG triggers across NUM_SLOT issue slots. Adds per-trigger match modes (mask, >=, <), sequential chaining of adjacent trigger pairs, and per-trigger hit counting to the basic PC mask-match. Outputs are registered one cycle and feed the TLU debug/breakpoint logic. A sticky per-trigger hit status is also provided.

---
 rtl/dec_trigger_seq.sv | 278 +++++++++++++++++++++++++++
 tb/tb_dec_trigger_seq.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dec_trigger_seq.sv
// ---------------------------------------------------------------------------
// dec_trigger_seq
//
// Decode-stage PC execute-trigger unit. Each of NUM_TRIG triggers compares the
// PC of every decode slot against its tdata2 value using a per-trigger mode
// (mask-match, >=, <, never). Adjacent trigger pairs can be chained so that
// the second trigger only fires after the first has matched. An optional hit
// counter per trigger requires several matches before a fire. Fires are
// registered one cycle and feed the TLU debug/breakpoint logic. A sticky hit
// bit per trigger records that the trigger fired.
//
// Build option:
//   DEC_TRIG_COUNT_EN  defined   -> per-trigger hit counters, at most one
//                                   fire per trigger per cycle.
//                      undefined -> no counters, trig_count is ignored and
//                                   every qualifying slot fires.
//
// Parameters:
//   NUM_TRIG  number of triggers (2..8)
//   NUM_SLOT  number of decode slots (1..4), slot 0 is the oldest
//   CNT_W     width of each per-trigger hit counter
//
// Ports:
//   clk            clock
//   rst            synchronous active-high reset
//   trig_execute   execute-type trigger enable, one bit per trigger
//   trig_m         machine-mode enable, one bit per trigger
//   trig_select    opcode select; such a trigger never matches here
//   trig_mode      2 bits per trigger: 0 mask, 1 >=, 2 <, 3 never
//   trig_chain     bit i chains trigger i to trigger i+1 (MSB ignored)
//   trig_tdata2    32-bit compare value / mask per trigger
//   trig_count     hits required to fire per trigger (0 acts as 1)
//   trig_wr        trigger config written: reload counter, disarm chain
//   slot_valid     decode slot holds a valid instruction
//   slot_pc        PC[31:1] per decode slot
//   flush          kill all decode slots this cycle, freeze all state
//   hit_clr        clear sticky hit bits
//   trigger_match  registered fire vector, index [s*NUM_TRIG+i]
//   trigger_hit    sticky hit status per trigger
//   chain_armed    arm state of each chain head
// ---------------------------------------------------------------------------
module dec_trigger_seq #(
    parameter int NUM_TRIG = 4,
    parameter int NUM_SLOT = 2,
    parameter int CNT_W    = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_TRIG-1:0]          trig_execute,
    input  logic [NUM_TRIG-1:0]          trig_m,
    input  logic [NUM_TRIG-1:0]          trig_select,
    input  logic [2*NUM_TRIG-1:0]        trig_mode,
    input  logic [NUM_TRIG-1:0]          trig_chain,
    input  logic [32*NUM_TRIG-1:0]       trig_tdata2,
    input  logic [CNT_W*NUM_TRIG-1:0]    trig_count,
    input  logic [NUM_TRIG-1:0]          trig_wr,
    input  logic [NUM_SLOT-1:0]          slot_valid,
    input  logic [31*NUM_SLOT-1:0]       slot_pc,
    input  logic                         flush,
    input  logic [NUM_TRIG-1:0]          hit_clr,
    output logic [NUM_SLOT*NUM_TRIG-1:0] trigger_match,
    output logic [NUM_TRIG-1:0]          trigger_hit,
    output logic [NUM_TRIG-1:0]          chain_armed
);

    typedef enum logic [1:0] {
        MODE_MASK  = 2'd0,
        MODE_GE    = 2'd1,
        MODE_LT    = 2'd2,
        MODE_NEVER = 2'd3
    } match_mode_e;

    // The last trigger has no partner, so it can never be a chain head.
    localparam logic [NUM_TRIG-1:0] HEAD_OK = {1'b0, {(NUM_TRIG-1){1'b1}}};

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic [NUM_SLOT-1:0][NUM_TRIG-1:0] raw;     // qualified compare hit
    logic [NUM_SLOT-1:0][NUM_TRIG-1:0] cand;    // fire candidate after chaining
    logic [NUM_SLOT-1:0][NUM_TRIG-1:0] fire;    // final fire after counting

    logic [NUM_TRIG-1:0] head;      // trigger i heads a chain pair (i, i+1)
    logic [NUM_TRIG-1:0] tail;      // trigger i is the second of a pair
    logic [NUM_TRIG-1:0] wr_pair;   // config write to either half of a pair
    logic [NUM_TRIG-1:0] fire_any;

    logic [NUM_SLOT*NUM_TRIG-1:0] match_q;
    logic [NUM_TRIG-1:0]          hit_q,   hit_d;
    logic [NUM_TRIG-1:0]          armed_q, armed_d;

    // ------------------------------------------------------------------
    // Compare helpers
    // ------------------------------------------------------------------
    // Bit b is don't-care when every bit below it in tdata2 is one. That
    // covers the trailing-ones run tdata2[k:0] plus bit k+1, and nothing
    // when tdata2[0] is zero (exact compare).
    function automatic logic [31:0] dont_care_mask(input logic [31:0] tdata2);
        logic [31:0] m;
        logic        run;
        m    = '0;
        m[0] = tdata2[0];
        run  = tdata2[0];
        for (int b = 1; b < 32; b++) begin
            m[b] = run;
            run  = run & tdata2[b];
        end
        return m;
    endfunction

    function automatic logic cmp_match(input logic [1:0]  mode,
                                       input logic [31:0] data,
                                       input logic [31:0] tdata2);
        logic hit;
        case (match_mode_e'(mode))
            MODE_MASK: hit = ((data ^ tdata2) & ~dont_care_mask(tdata2)) == 32'd0;
            MODE_GE:   hit = data >= tdata2;
            MODE_LT:   hit = data < tdata2;
            default:   hit = 1'b0;
        endcase
        return hit;
    endfunction

    // ------------------------------------------------------------------
    // Raw per-slot, per-trigger match
    // ------------------------------------------------------------------
    always_comb begin
        raw = '0;
        for (int s = 0; s < NUM_SLOT; s++) begin
            for (int i = 0; i < NUM_TRIG; i++) begin
                raw[s][i] = slot_valid[s] & ~flush & trig_execute[i] & trig_m[i]
                          & ~trig_select[i]
                          & cmp_match(trig_mode[2*i +: 2],
                                      {slot_pc[31*s +: 31], 1'b0},
                                      trig_tdata2[32*i +: 32]);
            end
        end
    end

    // ------------------------------------------------------------------
    // Chaining
    // ------------------------------------------------------------------
    // A chain bit is ignored when the bit below it is set, so pairs never
    // overlap or cascade.
    assign head    = trig_chain & ~{trig_chain[NUM_TRIG-2:0], 1'b0} & HEAD_OK;
    assign tail    = {head[NUM_TRIG-2:0], 1'b0};
    assign wr_pair = trig_wr | {1'b0, trig_wr[NUM_TRIG-1:1]};

    // Walk the slots oldest first. 'seen' holds, at each tail position, whether
    // the head was armed earlier or matched in an older slot this cycle.
    always_comb begin : cand_comb
        logic [NUM_TRIG-1:0] seen;
        cand = '0;
        // NOTE: 'seen' is a combinational accumulator updated slot by slot,
        // so it uses blocking assignments; registers below use non-blocking.
        seen = {armed_q[NUM_TRIG-2:0], 1'b0};
        for (int s = 0; s < NUM_SLOT; s++) begin
            cand[s] = raw[s] & ~head & (~tail | seen);
            seen    = seen | {raw[s][NUM_TRIG-2:0], 1'b0};
        end
    end

    // ------------------------------------------------------------------
    // Hit counting (optional)
    // ------------------------------------------------------------------
`ifdef DEC_TRIG_COUNT_EN
    logic [NUM_TRIG-1:0][CNT_W-1:0] cnt_q, cnt_d;

    function automatic logic [CNT_W-1:0] reload_val(input logic [CNT_W-1:0] v);
        return (v == '0) ? CNT_W'(1) : v;
    endfunction

    // Candidates are consumed oldest slot first. The one that takes the
    // counter to zero fires and reloads it; later ones are dropped uncounted.
    // A config write drops every candidate of that trigger.
    always_comb begin : count_comb
        logic [CNT_W-1:0] c;
        logic             done;
        fire  = '0;
        cnt_d = cnt_q;
        c     = '0;
        done  = 1'b0;
        for (int i = 0; i < NUM_TRIG; i++) begin
            c    = cnt_q[i];
            done = trig_wr[i];
            for (int s = 0; s < NUM_SLOT; s++) begin
                if (cand[s][i] && !done) begin
                    if (c <= CNT_W'(1)) begin
                        fire[s][i] = 1'b1;
                        done       = 1'b1;
                        c          = reload_val(trig_count[CNT_W*i +: CNT_W]);
                    end else begin
                        c = c - CNT_W'(1);
                    end
                end
            end
            if (flush) begin
                cnt_d[i] = cnt_q[i];
            end else if (trig_wr[i]) begin
                cnt_d[i] = reload_val(trig_count[CNT_W*i +: CNT_W]);
            end else begin
                cnt_d[i] = c;
            end
        end
    end

    // NOTE: counters are control state, not storage, so they get a reset
    // value (1 = fire on the next hit) like every other register here.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= {NUM_TRIG{CNT_W'(1)}};
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_trig_count;
    assign unused_trig_count = ^trig_count;
    assign fire = cand;
`endif

    // ------------------------------------------------------------------
    // Chain arm state
    // ------------------------------------------------------------------
    // Per slot: a head match arms, then a tail fire in that same slot
    // disarms. A head match in a younger slot than the fire re-arms.
    always_comb begin : arm_comb
        logic [NUM_TRIG-1:0] nxt;
        nxt = armed_q;
        for (int s = 0; s < NUM_SLOT; s++) begin
            nxt = nxt | raw[s];
            nxt = nxt & ~{1'b0, fire[s][NUM_TRIG-1:1]};
        end
        // A flushed cycle freezes the arm state, config writes included.
        if (flush) begin
            armed_d = armed_q & head;
        end else begin
            armed_d = nxt & head & ~wr_pair;
        end
    end

    // ------------------------------------------------------------------
    // Sticky hit status: set wins over clear, flush freezes it
    // ------------------------------------------------------------------
    always_comb begin
        fire_any = '0;
        for (int s = 0; s < NUM_SLOT; s++) begin
            fire_any = fire_any | fire[s];
        end
        if (flush) begin
            hit_d = hit_q;
        end else begin
            hit_d = (hit_q & ~hit_clr) | fire_any;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // 'fire' is packed slot-major, so its flat image is already indexed
    // [s*NUM_TRIG+i].
    always_ff @(posedge clk) begin
        if (rst) begin
            match_q <= '0;
            hit_q   <= '0;
            armed_q <= '0;
        end else begin
            match_q <= fire;
            hit_q   <= hit_d;
            armed_q <= armed_d;
        end
    end

    assign trigger_match = match_q;
    assign trigger_hit   = hit_q;
    assign chain_armed   = armed_q;

endmodule

// File: tb/tb_dec_trigger_seq.sv
// ---------------------------------------------------------------------------
// tb_dec_trigger_seq
//
// Directed self-checking bench for dec_trigger_seq with default parameters
// (4 triggers, 2 slots, 8-bit counters). Inputs change 1 time unit after a
// rising edge; outputs are compared at that same point, i.e. after the edge
// that registered them. Counter expectations follow DEC_TRIG_COUNT_EN.
// ---------------------------------------------------------------------------
module tb_dec_trigger_seq;

    localparam int NT = 4;
    localparam int NS = 2;
    localparam int CW = 8;

    logic                  clk;
    logic                  rst;
    logic [NT-1:0]         trig_execute;
    logic [NT-1:0]         trig_m;
    logic [NT-1:0]         trig_select;
    logic [2*NT-1:0]       trig_mode;
    logic [NT-1:0]         trig_chain;
    logic [32*NT-1:0]      trig_tdata2;
    logic [CW*NT-1:0]      trig_count;
    logic [NT-1:0]         trig_wr;
    logic [NS-1:0]         slot_valid;
    logic [31*NS-1:0]      slot_pc;
    logic                  flush;
    logic [NT-1:0]         hit_clr;
    logic [NS*NT-1:0]      trigger_match;
    logic [NT-1:0]         trigger_hit;
    logic [NT-1:0]         chain_armed;

    int errors = 0;
    int checks = 0;

    dec_trigger_seq #(
        .NUM_TRIG (NT),
        .NUM_SLOT (NS),
        .CNT_W    (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .trig_execute  (trig_execute),
        .trig_m        (trig_m),
        .trig_select   (trig_select),
        .trig_mode     (trig_mode),
        .trig_chain    (trig_chain),
        .trig_tdata2   (trig_tdata2),
        .trig_count    (trig_count),
        .trig_wr       (trig_wr),
        .slot_valid    (slot_valid),
        .slot_pc       (slot_pc),
        .flush         (flush),
        .hit_clr       (hit_clr),
        .trigger_match (trigger_match),
        .trigger_hit   (trigger_hit),
        .chain_armed   (chain_armed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_trig(input int i, input logic [1:0] mode,
                            input logic [31:0] tdata2, input logic [CW-1:0] cnt);
        trig_mode[2*i +: 2]     = mode;
        trig_tdata2[32*i +: 32] = tdata2;
        trig_count[CW*i +: CW]  = cnt;
    endtask

    task automatic set_slot(input int s, input logic v, input logic [31:0] pc);
        slot_valid[s]       = v;
        slot_pc[31*s +: 31] = pc[31:1];
    endtask

    task automatic idle_slots();
        slot_valid = '0;
    endtask

    initial begin
        rst          = 1'b1;
        trig_execute = '1;
        trig_m       = '1;
        trig_select  = '0;
        trig_mode    = '1;       // all triggers "never"
        trig_chain   = '0;
        trig_tdata2  = '0;
        trig_count   = '0;
        trig_wr      = '0;
        slot_valid   = '0;
        slot_pc      = '0;
        flush        = 1'b0;
        hit_clr      = '0;

        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst_match", 32'(trigger_match), 32'h0);
        check("rst_hit",   32'(trigger_hit),   32'h0);
        check("rst_armed", 32'(chain_armed),   32'h0);
        rst = 1'b0;

        // ---------------- mask mode ----------------
        set_trig(0, 2'd0, 32'h0000_1007, 8'd0);
        set_slot(0, 1'b1, 32'h0000_1000);
        tick();
        check("mask_hit",       32'(trigger_match), 32'h01);
        check("mask_hit_stick", 32'(trigger_hit),   32'h1);
        set_slot(0, 1'b1, 32'h0000_1010);
        tick();
        check("mask_miss", 32'(trigger_match), 32'h00);
        set_slot(0, 1'b1, 32'h0000_100e);
        tick();
        check("mask_dc_bits", 32'(trigger_match), 32'h01);
        idle_slots();
        hit_clr = '1;
        tick();
        check("hit_clr_all", 32'(trigger_hit), 32'h0);
        hit_clr = '0;

        // ---------------- range modes ----------------
        set_trig(0, 2'd3, 32'h0, 8'd0);
        set_trig(1, 2'd1, 32'h0000_2000, 8'd0);
        set_trig(2, 2'd2, 32'h0000_3000, 8'd0);
        set_slot(1, 1'b1, 32'h0000_2ffe);
        tick();
        check("range_both", 32'(trigger_match), 32'h60);
        set_slot(1, 1'b1, 32'h0000_3000);
        tick();
        check("range_lt_edge", 32'(trigger_match), 32'h20);
        set_slot(1, 1'b0, 32'h0);
        set_slot(0, 1'b1, 32'h0000_1ffe);
        tick();
        check("range_ge_edge", 32'(trigger_match), 32'h04);
        idle_slots();

        // ---------------- chaining ----------------
        set_trig(0, 2'd0, 32'h0000_0100, 8'd0);
        set_trig(1, 2'd0, 32'h0000_0200, 8'd0);
        set_trig(2, 2'd3, 32'h0, 8'd0);
        trig_chain = 4'b0001;
        set_slot(1, 1'b1, 32'h0000_0200);
        tick();
        check("chain_tail_alone", 32'(trigger_match), 32'h00);
        idle_slots();
        set_slot(0, 1'b1, 32'h0000_0100);
        tick();
        check("chain_head_nofire", 32'(trigger_match), 32'h00);
        check("chain_armed_set",   32'(chain_armed),   32'h1);
        set_slot(0, 1'b1, 32'h0000_0200);
        tick();
        check("chain_fire_prior",  32'(trigger_match), 32'h02);
        check("chain_armed_clr",   32'(chain_armed),   32'h0);
        set_slot(0, 1'b1, 32'h0000_0100);
        set_slot(1, 1'b1, 32'h0000_0200);
        tick();
        check("chain_fire_same",   32'(trigger_match), 32'h20);
        check("chain_same_clr",    32'(chain_armed),   32'h0);
        set_slot(0, 1'b1, 32'h0000_0200);
        set_slot(1, 1'b1, 32'h0000_0100);
        tick();
        check("chain_wrong_order", 32'(trigger_match), 32'h00);
        check("chain_late_arm",    32'(chain_armed),   32'h1);
        tick();
        check("chain_fire_rearm",  32'(trigger_match), 32'h02);
        check("chain_rearmed",     32'(chain_armed),   32'h1);
        idle_slots();

        // ---------------- trig_wr and flush on a chain ----------------
        trig_wr = 4'b0010;
        tick();
        check("wr_disarm", 32'(chain_armed), 32'h0);
        trig_wr = '0;
        set_slot(0, 1'b1, 32'h0000_0200);
        tick();
        check("wr_no_fire", 32'(trigger_match), 32'h00);
        set_slot(0, 1'b1, 32'h0000_0100);
        trig_wr = 4'b0001;
        tick();
        check("wr_over_arm", 32'(chain_armed), 32'h0);
        trig_wr = '0;
        flush   = 1'b1;
        tick();
        check("flush_no_arm", 32'(chain_armed), 32'h0);
        flush = 1'b0;
        tick();
        check("arm_again", 32'(chain_armed), 32'h1);
        set_slot(0, 1'b1, 32'h0000_0200);
        flush = 1'b1;
        tick();
        check("flush_no_match", 32'(trigger_match), 32'h00);
        check("flush_keep_arm", 32'(chain_armed),   32'h1);
        flush = 1'b0;
        tick();
        check("after_flush_fire", 32'(trigger_match), 32'h02);
        idle_slots();

        // ---------------- counting ----------------
        trig_chain = '0;
        set_trig(0, 2'd0, 32'h0000_0400, 8'd3);
        set_trig(1, 2'd3, 32'h0, 8'd0);
        trig_wr = 4'b0001;
        tick();
        trig_wr = '0;
        set_slot(0, 1'b1, 32'h0000_0400);
        set_slot(1, 1'b1, 32'h0000_0400);
`ifdef DEC_TRIG_COUNT_EN
        tick();
        check("cnt_cycle1", 32'(trigger_match), 32'h00);
        tick();
        check("cnt_cycle2", 32'(trigger_match), 32'h01);
        flush = 1'b1;
        tick();
        check("cnt_flush", 32'(trigger_match), 32'h00);
        flush = 1'b0;
        tick();
        check("cnt_reload", 32'(trigger_match), 32'h00);
        set_slot(1, 1'b0, 32'h0);
        tick();
        check("cnt_flush_held", 32'(trigger_match), 32'h01);
        set_slot(1, 1'b1, 32'h0000_0400);
        trig_wr = 4'b0001;
        tick();
        check("cnt_wr_discard", 32'(trigger_match), 32'h00);
        trig_wr = '0;
        tick();
        check("cnt_after_wr", 32'(trigger_match), 32'h00);
        set_slot(0, 1'b0, 32'h0);
        tick();
        check("cnt_slot1_fire", 32'(trigger_match), 32'h10);
`else
        tick();
        check("nocnt_cycle1", 32'(trigger_match), 32'h11);
        tick();
        check("nocnt_cycle2", 32'(trigger_match), 32'h11);
        flush = 1'b1;
        tick();
        check("nocnt_flush", 32'(trigger_match), 32'h00);
        flush = 1'b0;
        tick();
        check("nocnt_both", 32'(trigger_match), 32'h11);
        set_slot(1, 1'b0, 32'h0);
        tick();
        check("nocnt_slot0", 32'(trigger_match), 32'h01);
        set_slot(1, 1'b1, 32'h0000_0400);
        trig_wr = 4'b0001;
        tick();
        check("nocnt_wr", 32'(trigger_match), 32'h11);
        trig_wr = '0;
        set_slot(0, 1'b0, 32'h0);
        tick();
        check("nocnt_slot1", 32'(trigger_match), 32'h10);
`endif
        idle_slots();

        // ---------------- sticky hit and reset ----------------
        hit_clr = '1;
        tick();
        check("sticky_clr", 32'(trigger_hit), 32'h0);
        hit_clr = '0;
        set_trig(0, 2'd0, 32'h0000_0400, 8'd0);
        trig_wr = 4'b0001;
        tick();
        trig_wr = '0;
        set_slot(0, 1'b1, 32'h0000_0400);
        tick();
        check("sticky_fire",  32'(trigger_match), 32'h01);
        check("sticky_set",   32'(trigger_hit),   32'h1);
        hit_clr = 4'b0001;
        tick();
        check("sticky_set_wins", 32'(trigger_hit), 32'h1);
        idle_slots();
        tick();
        check("sticky_cleared", 32'(trigger_hit), 32'h0);
        hit_clr = '0;
        set_slot(0, 1'b1, 32'h0000_0400);
        tick();
        check("sticky_reset_prep", 32'(trigger_hit), 32'h1);
        trig_chain = 4'b0001;
        tick();
        check("armed_reset_prep", 32'(chain_armed), 32'h1);
        rst = 1'b1;
        tick();
        check("rst2_match", 32'(trigger_match), 32'h0);
        check("rst2_hit",   32'(trigger_hit),   32'h0);
        check("rst2_armed", 32'(chain_armed),   32'h0);
        rst = 1'b0;
        idle_slots();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
